ddr3_write_axi_bridge: RTL
==========================

DDR3_WRITE_AXI_BRIDGE -- requirements
Module: ddr3_write_axi_bridge

Interface
REQ-001 Parameter AP, default 1'b0: value driven on axi_awuser_ap (auto-precharge request) for every burst.
REQ-002 Parameter ID, default 4'd0: value driven on axi_awuser_id for every burst.
REQ-003 Parameter TIMEOUT, default 1023: max cycles in ADDR or DATA state without progress before error.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ddr_init_done  in  1  DDR3 calibration complete.
REQ-007 WRITE_ADDR  in  28  burst start address, 256-bit-word aligned (bits [2:0] = 0).
REQ-008 WRITE_LEN  in  4  beats minus one (0..15).
REQ-009 WRITE_ADDR_VALID  in  1  upstream address request.
REQ-010 WRITE_ADDR_READY  out  1  address accepted when high with VALID.
REQ-011 WRITE_DATA  in  256  current beat, valid whenever bridge is in DATA state (upstream prefetched FIFO).
REQ-012 WRITE_STRB  in  32  byte enables for WRITE_DATA.
REQ-013 WRITE_DATA_READY  out  1  beat consumed this cycle; upstream advances its FIFO.
REQ-014 WRITE_DATA_LAST  out  1  high with READY on final beat of burst.
REQ-015 axi_awaddr  out  28  / axi_awlen  out  4 / axi_awuser_ap  out  1 / axi_awuser_id  out  4: registered burst command to DDR3 IP.
REQ-016 axi_awvalid  out  1 / axi_awready  in  1: IP address handshake.
REQ-017 axi_wdata  out  256 / axi_wstrb  out  32: beat to IP.
REQ-018 axi_wready  in  1: IP accepts beat this cycle.
REQ-019 axi_wusero_last  in  1: IP's own last-beat indication.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 err  out  1  sticky error flag.

Function
REQ-022 States: IDLE, ADDR, DATA; encoding free.
REQ-023 IDLE: WRITE_ADDR_READY = ddr_init_done (combinational); on READY&&VALID, latch WRITE_ADDR, WRITE_LEN into command registers, clear beat counter, go ADDR next cycle.
REQ-024 ADDR: axi_awvalid = 1, command registers drive axi_aw*; on axi_awready go DATA next cycle; command must stay stable while awvalid high.
REQ-025 DATA: WRITE_DATA_READY = axi_wready (combinational, no added latency); axi_wdata/axi_wstrb = WRITE_DATA/WRITE_STRB (pass-through).
REQ-026 4-bit beat counter increments on each axi_wready in DATA; WRITE_DATA_LAST = axi_wready && (count == latched len).
REQ-027 On WRITE_DATA_LAST return to IDLE; next address accepted no earlier than the following cycle (min 1 idle cycle between bursts).
REQ-028 Outside DATA: WRITE_DATA_READY = 0, WRITE_DATA_LAST = 0; axi_wdata/axi_wstrb still pass through; IP ignores them (no wvalid).
REQ-029 Outside IDLE: WRITE_ADDR_READY = 0; outside ADDR: axi_awvalid = 0.
REQ-030 len = 0: single beat, LAST with first axi_wready.
REQ-031 Mismatch: axi_wusero_last high on a wready beat where counter != len, or counter == len with axi_wusero_last low -> set err; burst still completes on internal count.
REQ-032 Watchdog counter resets on every state change and every wready beat; reaching TIMEOUT in ADDR or DATA sets err; state unchanged (no abort).
REQ-033 err cleared only by rst.
REQ-034 ddr_init_done falling mid-burst: burst continues to completion; only new address acceptance is gated.

Reset
REQ-035 rst forces IDLE from any state, including mid-burst; no partial beats or LAST afterwards.
REQ-036 Reset values: WRITE_ADDR_READY 0 (until released and ddr_init_done), axi_awvalid 0, WRITE_DATA_READY 0, WRITE_DATA_LAST 0, busy 0, err 0, command registers 0, beat counter 0, watchdog 0.

Verification
REQ-037 Single beat: ADDR 0x0000100 LEN 0, awready immediate, wready next -> awaddr 0x0000100, awlen 0, one READY with LAST, IDLE after.
REQ-038 Full burst with backpressure: LEN 15, wready toggling 1/0 -> exactly 16 READY pulses, LAST only on 16th, data/strb pass-through matched per beat.
REQ-039 Back-to-back: two bursts VALID continuously, awready held high -> second address accepted one cycle after first LAST, no overlap.
REQ-040 Mismatch: LEN 3, IP asserts axi_wusero_last on beat 2 -> err = 1, LAST still on beat 4.
REQ-041 Timeout: TIMEOUT 15, awready held low -> err set at 15th ADDR cycle, awvalid stays high; awready then high -> burst completes normally.
REQ-042 Reset mid-burst: rst on beat 5 of LEN 7 -> next cycle IDLE, READY/LAST/awvalid/err 0; new burst accepted after release.

Source files
------------

// File: rtl/ddr3_write_axi_bridge_if.sv
// rtl/ddr3_write_axi_bridge_if.sv - upstream write request and DDR3 IP write-channel bundle
interface ddr3_write_axi_bridge_if;
    logic         ddr_init_done;

    logic [27:0]  WRITE_ADDR;
    logic [3:0]   WRITE_LEN;
    logic         WRITE_ADDR_VALID;
    logic         WRITE_ADDR_READY;
    logic [255:0] WRITE_DATA;
    logic [31:0]  WRITE_STRB;
    logic         WRITE_DATA_READY;
    logic         WRITE_DATA_LAST;

    logic [27:0]  axi_awaddr;
    logic [3:0]   axi_awlen;
    logic         axi_awuser_ap;
    logic [3:0]   axi_awuser_id;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wready;
    logic         axi_wusero_last;

    logic         busy;
    logic         err;

    // bridge side
    modport master (
        input  ddr_init_done,
        input  WRITE_ADDR, WRITE_LEN, WRITE_ADDR_VALID, WRITE_DATA, WRITE_STRB,
        output WRITE_ADDR_READY, WRITE_DATA_READY, WRITE_DATA_LAST,
        output axi_awaddr, axi_awlen, axi_awuser_ap, axi_awuser_id, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb,
        input  axi_wready, axi_wusero_last,
        output busy, err
    );

    // upstream FIFO and DDR3 IP side
    modport slave (
        output ddr_init_done,
        output WRITE_ADDR, WRITE_LEN, WRITE_ADDR_VALID, WRITE_DATA, WRITE_STRB,
        input  WRITE_ADDR_READY, WRITE_DATA_READY, WRITE_DATA_LAST,
        input  axi_awaddr, axi_awlen, axi_awuser_ap, axi_awuser_id, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb,
        output axi_wready, axi_wusero_last,
        input  busy, err
    );
endinterface

// File: rtl/ddr3_write_axi_bridge.sv
// rtl/ddr3_write_axi_bridge.sv - upstream burst write requests to DDR3 IP AXI-style write channel
module ddr3_write_axi_bridge #(
    parameter logic       AP      = 1'b0,
    parameter logic [3:0] ID      = 4'd0,
    parameter int         TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    ddr3_write_axi_bridge_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_ERR = WDW'(TIMEOUT - 1);

    logic [1:0]     state;
    logic [27:0]    cmd_addr;
    logic [3:0]     cmd_len;
    logic [3:0]     beat_cnt;
    logic [WDW-1:0] wdog;
    logic           err_q;

    logic addr_ready;
    logic addr_fire;
    logic aw_fire;
    logic beat_fire;
    logic final_beat;
    logic progress;

    assign addr_ready = !rst && (state == S_IDLE) && bus.ddr_init_done;
    assign addr_fire  = addr_ready && bus.WRITE_ADDR_VALID;
    assign aw_fire    = (state == S_ADDR) && bus.axi_awready;
    assign beat_fire  = (state == S_DATA) && bus.axi_wready;
    assign final_beat = beat_fire && (beat_cnt == cmd_len);
    // every state change and every accepted beat counts as forward progress
    assign progress   = addr_fire || aw_fire || beat_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd_addr <= 28'd0;
            cmd_len  <= 4'd0;
            beat_cnt <= 4'd0;
            wdog     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (addr_fire) begin
                        cmd_addr <= bus.WRITE_ADDR;
                        cmd_len  <= bus.WRITE_LEN;
                        beat_cnt <= 4'd0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (aw_fire) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (final_beat) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if ((state == S_IDLE) || progress) begin
                wdog <= '0;
            end else if (wdog != WD_MAX) begin
                wdog <= wdog + 1'b1;
            end

            // the IP's own last flag must agree with our beat count; burst completion ignores it
            if (beat_fire && (bus.axi_wusero_last != (beat_cnt == cmd_len))) begin
                err_q <= 1'b1;
            end
            if ((state != S_IDLE) && !progress && (wdog == WD_ERR)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.WRITE_ADDR_READY = addr_ready;
    assign bus.WRITE_DATA_READY = beat_fire;
    assign bus.WRITE_DATA_LAST  = final_beat;

    assign bus.axi_awaddr    = cmd_addr;
    assign bus.axi_awlen     = cmd_len;
    assign bus.axi_awuser_ap = AP;
    assign bus.axi_awuser_id = ID;
    assign bus.axi_awvalid   = (state == S_ADDR);

    // the IP has no wvalid; it only samples data on its own wready during a burst
    assign bus.axi_wdata = bus.WRITE_DATA;
    assign bus.axi_wstrb = bus.WRITE_STRB;

    assign bus.busy = (state != S_IDLE);
    assign bus.err  = err_q;

endmodule
